// File: rtl/led_pwm_port.sv
// rtl/led_pwm_port.sv - AVR I/O-mapped multi-channel LED driver (off/on/PWM/blink)
//
// Purpose:
//   Drives NUM_CH LED outputs from a shared prescaled PWM timebase. Each
//   channel is independently off, on, PWM-dimmed or blinking. Duty writes go
//   to a pending register and are copied to the active duty only at PWM frame
//   boundaries, so an LED never sees a partial or glitched frame.
//
// Parameters:
//   NUM_CH    LED channels, 1..16
//   PWM_BITS  PWM counter / duty width, 1..8
//   PRESCALE  clk cycles per PWM counter step, >= 1
//
// Ports:
//   clk       system clock
//   nrst      asynchronous active-low reset
//   io_addr   register address (0 CTRL, 1 SEL, 2 DUTY, 3 MODE, 4 BLINK)
//   io_we     write strobe, one cycle per write
//   io_din    write data
//   io_dout   read data, combinational from io_addr
//   led       registered LED outputs
//
// Configuration:
//   LEDPWM_BLINK_EN  when defined, implements blink mode, the BLINK register,
//                    the frame counter and the blink phase. When undefined,
//                    mode 11 behaves as PWM and BLINK reads 0.

module led_pwm_port #(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [2:0]        io_addr,
    input  logic              io_we,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    output logic [NUM_CH-1:0] led
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST   = '1;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_SEL   = 3'd1;
    localparam logic [2:0] A_DUTY  = 3'd2;
    localparam logic [2:0] A_MODE  = 3'd3;
    localparam logic [2:0] A_BLINK = 3'd4;

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_PWM   = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                             en_q,    en_d;
    logic                             inv_q,   inv_d;
    logic [3:0]                       sel_q,   sel_d;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  pend_q,  pend_d;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  act_q,   act_d;
    logic [NUM_CH-1:0][1:0]           mode_q,  mode_d;
    logic [PW-1:0]                    presc_q, presc_d;
    logic [PWM_BITS-1:0]              cnt_q,   cnt_d;
    logic [NUM_CH-1:0]                led_q,   led_d;
`ifdef LEDPWM_BLINK_EN
    logic [7:0]                       blink_q, blink_d;
    logic [7:0]                       fcnt_q,  fcnt_d;
    logic                             phase_q, phase_d;
`endif

    logic              wr_ctrl;
    logic              wr_sel;
    logic              wr_duty;
    logic              wr_mode;
    logic              tick;
    logic              frame_end;
    logic [NUM_CH-1:0] pwm_on;
    logic [NUM_CH-1:0] raw;

    assign wr_ctrl = io_we && (io_addr == A_CTRL);
    assign wr_sel  = io_we && (io_addr == A_SEL);
    assign wr_duty = io_we && (io_addr == A_DUTY);
    assign wr_mode = io_we && (io_addr == A_MODE);

    assign tick      = en_q && (presc_q == PRESC_LAST);
    assign frame_end = tick && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Register file next state. DUTY/MODE only land when SEL names an
    // existing channel; an out-of-range SEL simply matches no channel.
    // ------------------------------------------------------------------
    always_comb begin
        en_d   = en_q;
        inv_d  = inv_q;
        sel_d  = sel_q;
        pend_d = pend_q;
        mode_d = mode_q;
        if (wr_ctrl) begin
            en_d  = io_din[0];
            inv_d = io_din[1];
        end
        if (wr_sel) begin
            sel_d = io_din[3:0];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == 4'(i)) begin
                if (wr_duty) pend_d[i] = io_din[PWM_BITS-1:0];
                if (wr_mode) mode_d[i] = io_din[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Timebase and duty shadowing. The active duty copies pend_q (the value
    // before this edge), so a DUTY write coinciding with a frame end waits
    // for the following frame end.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        if (!en_q) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (!en_q || frame_end) begin
            act_d = pend_q;
        end
    end

`ifdef LEDPWM_BLINK_EN
    // Blink phase: half-period of BLINK frames; BLINK=0 pins the phase on.
    always_comb begin
        blink_d = blink_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (io_we && (io_addr == A_BLINK)) begin
            blink_d = io_din;
        end
        if (!en_q || (blink_q == 8'd0)) begin
            fcnt_d  = '0;
            phase_d = 1'b1;
        end else if (frame_end) begin
            if (fcnt_q == (blink_q - 8'd1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + 8'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-channel output
    // ------------------------------------------------------------------
    always_comb begin
        pwm_on = '0;
        raw    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_on[i] = (cnt_q < act_q[i]);
            case (mode_q[i])
                M_OFF:   raw[i] = 1'b0;
                M_ON:    raw[i] = 1'b1;
                M_PWM:   raw[i] = pwm_on[i];
`ifdef LEDPWM_BLINK_EN
                default: raw[i] = pwm_on[i] & phase_q;
`else
                default: raw[i] = pwm_on[i];
`endif
            endcase
        end
        led_d = en_q ? (raw ^ {NUM_CH{inv_q}}) : {NUM_CH{inv_q}};
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en_q    <= 1'b0;
            inv_q   <= 1'b0;
            sel_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            mode_q  <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
`ifdef LEDPWM_BLINK_EN
            blink_q <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b1;
`endif
        end else begin
            en_q    <= en_d;
            inv_q   <= inv_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
`ifdef LEDPWM_BLINK_EN
            blink_q <= blink_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign led = led_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_dout = '0;
        case (io_addr)
            A_CTRL: io_dout[1:0] = {inv_q, en_q};
            A_SEL:  io_dout[3:0] = sel_q;
            A_DUTY: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel_q == 4'(i)) io_dout[PWM_BITS-1:0] = pend_q[i];
                end
            end
            A_MODE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel_q == 4'(i)) io_dout[1:0] = mode_q[i];
                end
            end
`ifdef LEDPWM_BLINK_EN
            A_BLINK: io_dout = blink_q;
`endif
            default: io_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_port.sv
// tb/tb_led_pwm_port.sv - scoreboard bench for led_pwm_port against a time-based reference model

module tb_led_pwm_port;

    localparam int N     = 8;
    localparam int B     = 8;
    localparam int P     = 2;
    localparam int FRAME = P * (1 << B);

    logic         clk = 1'b0;
    logic         nrst;
    logic [2:0]   io_addr;
    logic         io_we;
    logic [7:0]   io_din;
    logic [7:0]   io_dout;
    logic [N-1:0] led;

    always #5 clk = ~clk;

    led_pwm_port #(.NUM_CH(N), .PWM_BITS(B), .PRESCALE(P)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .io_addr (io_addr),
        .io_we   (io_we),
        .io_din  (io_din),
        .io_dout (io_dout),
        .led     (led)
    );

    typedef struct {
        logic [N-1:0] led;
        logic [7:0]   rd;
    } exp_t;

    exp_t sbq[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   hi_total = 0;

    // Reference model: led derived from elapsed time since enable.
    bit     m_en, m_inv;
    int     m_sel, m_blink;
    int     m_pend[N], m_act[N], m_mode[N];
    longint m_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_sel = 0; m_blink = 0; m_t = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_act[i] = 0; m_mode[i] = 0;
        end
    endtask

    function automatic logic [N-1:0] model_led();
        logic [N-1:0] r;
        int pc;
        longint fr;
        r  = '0;
        if (!m_en) return {N{m_inv}};
        pc = int'((m_t / P) % (1 << B));
        fr = m_t / FRAME;
        for (int i = 0; i < N; i++) begin
            case (m_mode[i])
                0: r[i] = 1'b0;
                1: r[i] = 1'b1;
                2: r[i] = (pc < m_act[i]);
`ifdef LEDPWM_BLINK_EN
                default: r[i] = (pc < m_act[i]) &&
                                ((m_blink == 0) || (((fr / m_blink) % 2) == 0));
`else
                default: r[i] = (pc < m_act[i]) && (fr >= 0);
`endif
            endcase
        end
        return r ^ {N{m_inv}};
    endfunction

    function automatic logic [7:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0: return {6'b0, m_inv, m_en};
            3'd1: return 8'(m_sel);
            3'd2: return (m_sel < N) ? 8'(m_pend[m_sel]) : 8'h00;
            3'd3: return (m_sel < N) ? 8'(m_mode[m_sel]) : 8'h00;
`ifdef LEDPWM_BLINK_EN
            3'd4: return 8'(m_blink);
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input bit we, input logic [2:0] a, input logic [7:0] d);
        bit fe;
        fe = m_en && ((m_t % FRAME) == FRAME - 1);
        if (!m_en || fe) m_act = m_pend;
        if (m_en) m_t++; else m_t = 0;
        if (we) begin
            case (a)
                3'd0: begin m_en = d[0]; m_inv = d[1]; end
                3'd1: m_sel = int'(d[3:0]);
                3'd2: if (m_sel < N) m_pend[m_sel] = int'(d);
                3'd3: if (m_sel < N) m_mode[m_sel] = int'(d[1:0]);
                3'd4: m_blink = int'(d);
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive, model the edge, queue what the DUT must show.
    task automatic cyc(input bit we, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        #1;
        io_we = we; io_addr = a; io_din = d;
        @(posedge clk);
        e.led = model_led();
        model_edge(we, a, d);
        e.rd  = model_rd(a);
        sbq.push_back(e);
        #1 io_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 3'($urandom_range(0, 7)), 8'h00);
    endtask

    // High samples of led[0] over exactly one frame.
    task automatic frame_hi(input int exp_hi, input string name);
        int snap;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 0; k++) idle(1);
        snap = hi_total;
        idle(FRAME);
        check(name, 64'(hi_total - snap), 64'(exp_hi));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        io_we = 1'b0;
        nrst  = 1'b0;
        #1;
        check("rst_led", 64'(led), 64'h0);
        for (int a = 0; a < 8; a++) begin
            io_addr = 3'(a);
            #1;
            check("rst_rd", 64'(io_dout), 64'h0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 nrst = 1'b1;
    endtask

    // Monitor: pops one expectation per DUT output cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        hi_total += int'(led[0]);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("led", 64'(led), 64'(e.led));
            check("dout", 64'(io_dout), 64'(e.rd));
        end
    end

    initial begin : driver
        int snap;
        int r;
        logic [2:0] a;
        logic [7:0] d;
        nrst = 1'b0; io_we = 1'b0; io_addr = '0; io_din = '0;
        model_reset();
        reset_pulse();

        // PWM on channel 0, duty 64
        cyc(1, 3'd1, 8'd0); cyc(1, 3'd3, 8'd2); cyc(1, 3'd2, 8'd64); cyc(1, 3'd0, 8'd1);
        idle(2 * FRAME);
        frame_hi(64 * P, "duty64");

        // mid-frame change 64 -> 192
        for (int k = 0; k < FRAME && (m_t % FRAME) != 0; k++) idle(1);
        snap = hi_total;
        idle(100);
        cyc(1, 3'd2, 8'd192);
        idle(FRAME - 101);
        check("duty_keep", 64'(hi_total - snap), 64'(64 * P));
        frame_hi(192 * P, "duty192");

        // DUTY write on the exact frame-end cycle
        for (int k = 0; k < FRAME && (m_t % FRAME) != FRAME - 1; k++) idle(1);
        cyc(1, 3'd2, 8'd32);
        frame_hi(192 * P, "fe_late");
        frame_hi(32 * P, "fe_apply");

        // blink, half-period 2 frames
        cyc(1, 3'd0, 8'd0); cyc(1, 3'd4, 8'd2); cyc(1, 3'd3, 8'd3); cyc(1, 3'd2, 8'd255);
        cyc(1, 3'd0, 8'd1);
        for (int f = 0; f < 6; f++) begin
`ifdef LEDPWM_BLINK_EN
            frame_hi((((f / 2) % 2) == 0) ? 255 * P : 0, "blink");
`else
            frame_hi(255 * P, "blink_off");
`endif
        end
        cyc(0, 3'd4, 8'd0);

        // INV with EN=0, then channel 3 forced on with INV
        cyc(1, 3'd0, 8'd2); idle(4);
        cyc(1, 3'd0, 8'd3); cyc(1, 3'd1, 8'd3); cyc(1, 3'd3, 8'd1); idle(3);

        // out-of-range SEL
        cyc(1, 3'd1, 8'(N)); cyc(1, 3'd2, 8'hAA); cyc(1, 3'd3, 8'd1);
        cyc(0, 3'd2, 8'd0); cyc(0, 3'd3, 8'd0); idle(4);

        reset_pulse();

        // randomized traffic
        cyc(1, 3'd0, 8'd1);
        for (int k = 0; k < 4000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                idle(1);
            end else begin
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 3'd0 && $urandom_range(0, 7) != 0) d = {6'b0, d[1], 1'b1};
                if (a == 3'd1) d = 8'($urandom_range(0, 9));
                if (a == 3'd4) begin
                    d = 8'($urandom_range(0, 3));
                    if (m_en) cyc(0, a, 8'd0);
                    else      cyc(1, a, d);
                end else begin
                    cyc(1, a, d);
                end
            end
        end

        reset_pulse();
        idle(4);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) check("drain", 64'(sbq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_port.md
# led_pwm_port

AVR I/O-mapped LED driver peripheral, the parametrised successor of the plain 8-bit LED output port on the soft core. Drives NUM_CH LED outputs, each independently off, on, PWM-dimmed, or blinking, from a shared prescaled PWM timebase. Registers sit on the AVR I/O bus; duty changes are shadowed to frame boundaries so LEDs never glitch. Instantiated next to the core in the board top.

## Interface
- NUM_CH, 8: LED channels, 1..16
- PWM_BITS, 8: PWM counter/duty width, 1..8
- PRESCALE, 64: clk cycles per PWM counter step, ≥1
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- io_addr  in  3  register address
- io_we  in  1  write strobe, one cycle per write
- io_din  in  8  write data
- io_dout  out  8  read data, combinational from io_addr
- led  out  NUM_CH  registered LED outputs

## Operation
- Registers:
  - 0 CTRL: bit0 EN, bit1 INV; other bits read 0.
  - 1 SEL: channel index, 4 bits.
  - 2 DUTY: pending duty of channel SEL, low PWM_BITS bits.
  - 3 MODE: bits[1:0] of channel SEL: 00 off, 01 on, 10 pwm, 11 blink.
  - 4 BLINK: half-period in PWM frames.
  - Addresses 5–7 read 0; writes to them are ignored.
- SEL ≥ NUM_CH: DUTY/MODE writes ignored, reads return 0.
- Timebase:
  - Prescaler counts 0..PRESCALE-1 while EN=1; tick when it equals PRESCALE-1, then it wraps to 0.
  - pwm_cnt (PWM_BITS) increments on each tick and wraps modulo 2^PWM_BITS.
  - Frame end = the tick on which pwm_cnt wraps to 0.
- Shadowing: at each frame end every channel's active duty loads from its pending duty.
  - A DUTY write in the same cycle as a frame end is not captured by that load; it takes effect at the next frame end.
- Blink: frame counter (8 bits) increments each frame end.
  - When it equals BLINK-1, it clears and phase toggles.
  - BLINK=0 holds phase=1 and the frame counter at 0.
- Per-channel raw output:
  - off: 0
  - on: 1
  - pwm: pwm_cnt < active duty
  - blink: (pwm_cnt < active duty) AND phase
- led[i] <= raw[i] XOR INV, registered.
- EN=0:
  - Prescaler, pwm_cnt, frame counter held at 0; phase held at 1.
  - Active duties load continuously from pending.
  - led = {NUM_CH{INV}}.
- Duty 0 in pwm mode gives constant 0; duty 2^PWM_BITS-1 gives on for all but one step per frame.

## Timing
- Reset (nrst low, asynchronous):
  - All registers, pending and active duties, counters and led = 0.
  - phase = 1; io_dout reflects reset register values.
- Writes take effect in the register on the rising edge where io_we=1.
- led reflects the counter/mode state one clk after the change: one-cycle output latency.
- MODE, INV and EN changes are visible on led one cycle after the write edge.
- DUTY changes are visible only after the next frame end.
- Frame length = PRESCALE × 2^PWM_BITS clk cycles.
- nrst asserted mid-frame discards all state immediately; no partial frame completes.

## Configuration
- LEDPWM_BLINK_EN defined: blink mode, BLINK register, frame counter and phase are implemented as above.
- LEDPWM_BLINK_EN undefined: mode 11 behaves as mode 10; BLINK reads 0 and writes are ignored; no frame counter or phase logic is synthesised.

## Test plan
- Reset with nrst low mid-operation -> led=0, all reads 0, within the same cycle for async clear of led.
- PRESCALE=1, PWM_BITS=8, EN=1, SEL=0, MODE=10, DUTY=64, one frame settled -> led[0] high exactly 64 of every 256 cycles; other channels 0.
- DUTY changed 64→192 mid-frame -> current frame keeps 64 high cycles; next frame 192; DUTY write on the exact frame-end cycle applies one frame later.
- MODE=11, DUTY=255, BLINK=2 -> led[0] PWM-active 2 frames, 0 for 2 frames, repeating; undefined LEDPWM_BLINK_EN -> continuous PWM, BLINK reads 0.
- INV=1, EN=0 -> led all 1; MODE=01 on channel 3 with EN=1, INV=1 -> led[3]=0 one cycle after the write.
- SEL=NUM_CH, write DUTY=0xAA and MODE=01 -> no channel changes; reads of DUTY/MODE return 0.
